i2c_target_rx: RTL and testbench
================================

// Module: i2c_target_rx
// PURPOSE
//  Write-only I2C target receiver placed directly upstream of the 7-segment controller top level.
//  - Synchronises the external SCL/SDA pins and detects START and STOP conditions.
//  - Matches a 7-bit address, ACKs each byte written to that address, and emits every received data byte as a 1-cycle strobe.
//  - The downstream segment register latches the byte on that strobe.
// PARAMETERS
//  ADDR         7'h28  7-bit target address that this block ACKs
//  SYNC_STAGES  2      flip-flop stages on the SCL and SDA inputs (minimum 2)
//  FILTER_LEN   3      consecutive equal samples needed to accept a level (only used with the filter macro)
// PORTS
//  clk        in   1  system clock; required to be at least 16x the SCL frequency
//  rst        in   1  synchronous reset, active-high
//  scl_in     in   1  raw SCL pin level (asynchronous)
//  sda_in     in   1  raw SDA pin level (asynchronous)
//  sda_oe     out  1  1 = pull SDA low (open-drain ACK), 0 = release SDA
//  rx_data    out  8  last received data byte, MSB first on the wire
//  rx_valid   out  1  1-cycle pulse: rx_data has just been updated
//  rx_first   out  1  qualifies rx_valid: this is the first data byte after the address
//  busy       out  1  high from an address match until STOP, repeated START or reset
// BEHAVIOUR
//  - Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, rx_first=0, busy=0, FSM=IDLE, bit counter=0.
//  - Input path: SCL/SDA pass through SYNC_STAGES flops, then one more register for edge detection.
//    Latency from pin change to event detection is SYNC_STAGES+1 clk.
//  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
//  - Data bits are sampled on the SCL rising edge and shifted into the register MSB first.
//  - Bit counter runs 0..7 and wraps to 0 when the ACK bit completes.
//  - FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
//    IDLE     --START--> ADDR.
//    ADDR     after 8 bits, on SCL falling:
//             - address == ADDR and R/W=0: -> ADDR_ACK; set sda_oe=1 and busy=1.
//             - otherwise (mismatch, or R/W=1): -> IGNORE; sda_oe stays 0 (NACK).
//    ADDR_ACK on the next SCL falling edge: sda_oe=0 -> DATA; arm rx_first.
//    DATA     after 8 bits, on SCL falling, in the same clk:
//             rx_data<=shift reg, rx_valid=1, rx_first=armed, sda_oe=1 -> DATA_ACK; then disarm rx_first.
//    DATA_ACK on the next SCL falling edge: sda_oe=0 -> DATA.
//    IGNORE   stays until START or STOP.
//  - STOP in any state: -> IDLE; sda_oe=0 and busy=0 in the cycle after detection.
//  - START in any state (repeated START): -> ADDR; bit counter=0; sda_oe=0.
//    A partial byte is discarded and rx_valid is not asserted for it.
//  - START and STOP cannot both be detected in one cycle, since each needs its own SDA edge.
//  - Exactly one rx_valid pulse per ACKed data byte; rx_data holds its value between pulses.
//  - sda_oe is only ever asserted while SCL is low or during the ACK bit, never during a data bit.
//  - Reset mid-transfer: all outputs return to reset values on the next clk edge.
//    The bus is released, and the next transfer starts clean at the next START.
//  - General call (address 0) is not supported and is treated as an address mismatch.
// CONFIGURATION
//  I2C_GLITCH_FILTER_EN
//  - Defined: after the synchroniser, SCL and SDA each pass through a counter filter.
//    The filtered level changes only after FILTER_LEN consecutive equal samples.
//    This adds FILTER_LEN clk of latency, and pulses shorter than FILTER_LEN clk are ignored.
//  - Undefined: no filter. Synchronised levels feed edge detection directly, with latency SYNC_STAGES+1.
// TESTING
//  1. START, addr 0x28+W, data 0xA5, STOP:
//     sda_oe=1 during both ACK bits; exactly 1 rx_valid with rx_data=0xA5 and rx_first=1; busy=0 after STOP.
//  2. START, addr 0x29+W, data 0x11, STOP:
//     sda_oe never asserted; no rx_valid; busy stays 0.
//  3. START, addr 0x28+R:
//     NACK (sda_oe=0 at the 9th clock); FSM in IGNORE; no rx_valid until the next START.
//  4. START, 0x28+W, bytes 0x01, 0x02, 0x03, STOP:
//     3 rx_valid pulses in order; rx_first=1 only on 0x01; 4 ACKs in total.
//  5. Repeated START after 5 data bits, then 0x28+W, 0x7E:
//     partial byte dropped; one rx_valid with 0x7E and rx_first=1.
//  6. Assert rst during a data-byte ACK:
//     sda_oe=0 and busy=0 on the next clk edge; a following full write of 0x3C is received correctly.
//     With I2C_GLITCH_FILTER_EN: a 1-clk low glitch on SCL mid-byte causes no extra sampled bit.

Source files
------------

// File: rtl/i2c_target_rx_if.sv
// I2C target receiver bus bundle: pin levels in, ACK drive and byte strobe out.
// master = bus/host side, slave = the receiver block.
interface i2c_target_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe,
    input  rx_data,
    input  rx_valid,
    input  rx_first,
    input  busy
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe,
    output rx_data,
    output rx_valid,
    output rx_first,
    output busy
  );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: sync, START/STOP detect, addr match, byte strobe.
// Optional macro I2C_GLITCH_FILTER_EN adds a FILTER_LEN-sample counter filter on SCL/SDA.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR        = 7'h28,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input logic            clk,
  input logic            rst,
  i2c_target_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("i2c_target_rx: SYNC_STAGES must be >= 2, FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   w_scl;
  logic                   w_sda;

  // Synchronise the asynchronous pins; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
    end
  end

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FLT_W =
    (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);

  logic             r_scl_flt;
  logic             r_sda_flt;
  logic [FLT_W-1:0] r_scl_cnt;
  logic [FLT_W-1:0] r_sda_cnt;

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (w_scl_s == r_scl_flt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FLT_MAX) begin
        r_scl_flt <= w_scl_s;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (w_sda_s == r_sda_flt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FLT_MAX) begin
        r_sda_flt <= w_sda_s;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = w_scl_s;
  assign w_sda = w_sda_s;
`endif

  logic r_scl_d;
  logic r_sda_d;

  // Previous-level register for edge and condition detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic       r_full;
  logic [7:0] r_shift;
  logic       r_armed;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_first;
  logic       r_busy;

  logic w_sample;
  logic w_byte_end;
  logic w_addr_hit;

  assign w_sample   = w_scl_rise & ~r_full;
  assign w_byte_end = w_scl_fall & r_full;
  assign w_addr_hit = (r_shift[7:1] == ADDR) &&
                      (r_shift[7:1] != 7'd0) &&
                      !r_shift[0];

  // Protocol FSM with registered bus and strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_full     <= 1'b0;
      r_shift    <= 8'h00;
      r_armed    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_full    <= 1'b0;
        r_armed   <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd0;
        r_full    <= 1'b0;
        r_armed   <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
          end
          S_ADDR, S_DATA: begin
            if (w_sample) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt == 3'd7) begin
                r_full <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else if (w_byte_end) begin
              r_full <= 1'b0;
              if (r_state == S_DATA) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_rx_first <= r_armed;
                r_armed    <= 1'b0;
                r_sda_oe   <= 1'b1;
                r_state    <= S_DATA_ACK;
              end else if (w_addr_hit) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= S_ADDR_ACK;
              end else begin
                r_bit_cnt <= 3'd0;
                r_state   <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_armed   <= 1'b1;
              r_state   <= S_DATA;
            end
          end
          S_DATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_state   <= S_DATA;
            end
          end
          S_IGNORE: begin
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_first = r_rx_first;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-level I2C master with open-drain SDA model
// and a scoreboard of expected {rx_first, rx_data} strobes.
module tb_i2c_target_rx;

  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_scl = 1'b1;
  logic r_sda_m = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int oe_rises = 0;
  logic oe_prev = 1'b0;

  logic [8:0] exp_q[$];

  i2c_target_rx_if bus ();

  assign bus.scl_in = r_scl;
  assign bus.sda_in = r_sda_m & ~bus.sda_oe;

  i2c_target_rx #(
    .ADDR(7'h28),
    .SYNC_STAGES(2),
    .FILTER_LEN(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard pop on every strobe, ACK-drive counting
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe: unexpected rx_valid data=%h first=%b",
                   bus.rx_data, bus.rx_first);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({bus.rx_first, bus.rx_data} !== e) begin
            n_err++;
            $display("FAIL strobe: got first=%b data=%h want first=%b data=%h",
                     bus.rx_first, bus.rx_data, e[8], e[7:0]);
          end
        end
      end
      if (bus.sda_oe && !oe_prev) oe_rises++;
    end
    oe_prev = bus.sda_oe;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!r_scl) begin
      r_sda_m = 1'b1;
      wclk(Q);
      r_scl = 1'b1;
      wclk(Q);
    end
    r_sda_m = 1'b0;
    wclk(2 * Q);
    r_scl = 1'b0;
    wclk(Q);
  endtask

  task automatic bus_stop();
    r_sda_m = 1'b0;
    wclk(Q);
    r_scl = 1'b1;
    wclk(Q);
    r_sda_m = 1'b1;
    wclk(3 * Q);
  endtask

  task automatic send_bit(input logic b);
    r_sda_m = b;
    wclk(Q);
    r_scl = 1'b1;
    wclk(2 * Q);
    r_scl = 1'b0;
    wclk(Q);
  endtask

  task automatic ack_bit(output logic ack);
    r_sda_m = 1'b1;
    wclk(Q);
    r_scl = 1'b1;
    wclk(Q);
    ack = bus.sda_oe;
    wclk(Q);
    r_scl = 1'b0;
    wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(ack);
  endtask

  task automatic chk(input string nm, input logic [8:0] got,
                     input logic [8:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wclk(4);
    n_vec++;
    if (bus.sda_oe !== 1'b0) begin
      n_err++; $display("FAIL rst_oe: got %b want 0", bus.sda_oe);
    end
    n_vec++;
    if (bus.rx_data !== 8'h00) begin
      n_err++; $display("FAIL rst_data: got %h want 00", bus.rx_data);
    end
    n_vec++;
    if ({bus.rx_valid, bus.rx_first, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_flags: got %b want 000",
               {bus.rx_valid, bus.rx_first, bus.busy});
    end
    rst = 1'b0;
    wclk(4);
  endtask

  task automatic test_single_write();
    logic a;
    int r0;
    r0 = oe_rises;
    bus_start();
    send_byte(8'h50, a);
    n_vec++;
    if (a !== 1'b1) begin
      n_err++; $display("FAIL t1_addr_ack: got %b want 1", a);
    end
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL t1_busy: got %b want 1", bus.busy);
    end
    exp_q.push_back({1'b1, 8'hA5});
    send_byte(8'hA5, a);
    n_vec++;
    if (a !== 1'b1) begin
      n_err++; $display("FAIL t1_data_ack: got %b want 1", a);
    end
    bus_stop();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL t1_busy_stop: got %b want 0", bus.busy);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL t1_drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (oe_rises - r0 != 2) begin
      n_err++; $display("FAIL t1_acks: got %0d want 2", oe_rises - r0);
    end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    int r0;
    r0 = oe_rises;
    bus_start();
    send_byte(8'h52, a);
    n_vec++;
    if (a !== 1'b0) begin
      n_err++; $display("FAIL t2_nack: got %b want 0", a);
    end
    send_byte(8'h11, a);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL t2_busy: got %b want 0", bus.busy);
    end
    bus_stop();
    n_vec++;
    if (oe_rises - r0 != 0) begin
      n_err++; $display("FAIL t2_oe: got %0d want 0", oe_rises - r0);
    end
  endtask

  task automatic test_read_nack();
    logic a;
    int r0;
    r0 = oe_rises;
    bus_start();
    send_byte(8'h51, a);
    n_vec++;
    if (a !== 1'b0) begin
      n_err++; $display("FAIL t3_nack: got %b want 0", a);
    end
    send_byte(8'h5A, a);
    send_byte(8'hC3, a);
    n_vec++;
    if ({bus.busy, a} !== 2'b00) begin
      n_err++; $display("FAIL t3_ignore: got %b want 00", {bus.busy, a});
    end
    bus_stop();
    n_vec++;
    if (oe_rises - r0 != 0) begin
      n_err++; $display("FAIL t3_oe: got %0d want 0", oe_rises - r0);
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    int r0;
    logic [7:0] d[3];
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
    r0 = oe_rises;
    bus_start();
    send_byte(8'h50, a);
    chk("t4_addr_ack", {8'h0, a}, 9'h1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({(i == 0), d[i]});
      send_byte(d[i], a);
      chk("t4_data_ack", {8'h0, a}, 9'h1);
    end
    bus_stop();
    chk("t4_acks", 9'(oe_rises - r0), 9'd4);
    chk("t4_drain", 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask

  task automatic test_repeated_start();
    logic a;
    bus_start();
    send_byte(8'h50, a);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    bus_start();
    chk("t5_busy_rs", {8'h0, bus.busy}, 9'h0);
    send_byte(8'h50, a);
    chk("t5_addr_ack", {8'h0, a}, 9'h1);
    exp_q.push_back({1'b1, 8'h7E});
    send_byte(8'h7E, a);
    chk("t5_data_ack", {8'h0, a}, 9'h1);
    bus_stop();
    chk("t5_drain", 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic a;
    bus_start();
    send_byte(8'h50, a);
    exp_q.push_back({1'b1, 8'h99});
    for (int i = 7; i >= 0; i--) send_bit(1'((8'h99 >> i) & 1));
    r_sda_m = 1'b1;
    wclk(Q);
    r_scl = 1'b1;
    wclk(Q);
    chk("t6_oe_pre", {8'h0, bus.sda_oe}, 9'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe_rst", {8'h0, bus.sda_oe}, 9'h0);
    chk("t6_busy_rst", {8'h0, bus.busy}, 9'h0);
    wclk(1);
    rst = 1'b0;
    wclk(Q);
    r_scl = 1'b0;
    wclk(Q);
    bus_stop();
    bus_start();
    send_byte(8'h50, a);
    chk("t6_addr_ack", {8'h0, a}, 9'h1);
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C, a);
    chk("t6_data_ack", {8'h0, a}, 9'h1);
    bus_stop();
    chk("t6_drain", 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a;
    logic [7:0] b;
    b = 8'hC3;
    bus_start();
    send_byte(8'h50, a);
    exp_q.push_back({1'b1, b});
    for (int i = 7; i >= 0; i--) begin
      r_sda_m = b[i];
      wclk(Q);
      r_scl = 1'b1;
      wclk(Q);
      if (i == 4) begin
        r_scl = 1'b0;
        wclk(1);
        r_scl = 1'b1;
        wclk(Q - 1);
      end else begin
        wclk(Q);
      end
      r_scl = 1'b0;
      wclk(Q);
    end
    ack_bit(a);
    chk("tg_ack", {8'h0, a}, 9'h1);
    bus_stop();
    chk("tg_drain", 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_addr_mismatch();
    test_read_nack();
    test_back_to_back();
    test_repeated_start();
    test_reset_mid();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    wclk(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
